// File: rtl/nvdla_sdp_core_split_if.sv
// rtl/nvdla_sdp_core_split_if.sv - handshake bundle for the SDP wide-to-narrow splitter
// Wide word side (inp_*) and narrow beat side (out_*) of the splitter.
interface nvdla_sdp_core_split_if #(
  parameter int IW = 512,
  parameter int OW = 128
);
  logic          inp_pvld;
  logic          inp_prdy;
  logic [IW-1:0] inp_data;
  logic [4:0]    inp_nseg;
  logic          out_pvld;
  logic          out_prdy;
  logic [OW-1:0] out_data;
  logic          out_last;

  modport slave (
    input  inp_pvld, inp_data, inp_nseg, out_prdy,
    output inp_prdy, out_pvld, out_data, out_last
  );

  modport master (
    output inp_pvld, inp_data, inp_nseg, out_prdy,
    input  inp_prdy, out_pvld, out_data, out_last
  );
endinterface

// File: rtl/nvdla_sdp_core_split.sv
// rtl/nvdla_sdp_core_split.sv - splits one IW-bit word into up to RATIO OW-bit beats
// One-entry holding register; segments go out lowest first, truncated by a per-word count.
module nvdla_sdp_core_split #(
  parameter int IW    = 512,
  parameter int OW    = 128,
  parameter int RATIO = IW / OW
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  nvdla_sdp_core_split_if.slave sdp
);
  localparam logic [4:0] RATIO_N = 5'(RATIO);

  logic [IW-1:0] hold_data_q;
  logic [4:0]    hold_nseg_q, hold_nseg_d;
  logic          hold_vld_q, hold_vld_d;
  logic [3:0]    seg_cnt_q, seg_cnt_d;

  logic [4:0]    nseg_norm;
  logic          is_last;
  logic          inp_rdy;
  logic          inp_acc;
  logic          out_acc;
  logic [OW-1:0] seg_sel;

  // A count of 0, or anything beyond the word's capacity, means a full word.
  always_comb begin
    nseg_norm = sdp.inp_nseg;
    if (sdp.inp_nseg == 5'd0 || sdp.inp_nseg > RATIO_N) begin
      nseg_norm = RATIO_N;
    end
  end

  assign is_last = ({1'b0, seg_cnt_q} == (hold_nseg_q - 5'd1));
  assign out_acc = hold_vld_q & sdp.out_prdy;
  assign inp_rdy = !hold_vld_q | (out_acc & is_last);
  assign inp_acc = sdp.inp_pvld & inp_rdy;

  always_comb begin
    seg_sel = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (seg_cnt_q == 4'(k)) begin
        seg_sel = hold_data_q[k*OW +: OW];
      end
    end
  end

  assign sdp.inp_prdy = inp_rdy;
  assign sdp.out_pvld = hold_vld_q;
  assign sdp.out_data = seg_sel;
  assign sdp.out_last = hold_vld_q & is_last;

  // A new word loading on the last-beat accept takes priority, so streaming has no bubble.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_nseg_d = hold_nseg_q;
    seg_cnt_d   = seg_cnt_q;
    if (inp_acc) begin
      hold_vld_d  = 1'b1;
      hold_nseg_d = nseg_norm;
      seg_cnt_d   = 4'd0;
    end else if (out_acc) begin
      if (is_last) begin
        hold_vld_d = 1'b0;
        seg_cnt_d  = 4'd0;
      end else begin
        seg_cnt_d = seg_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      hold_vld_q  <= 1'b0;
      hold_nseg_q <= RATIO_N;
      seg_cnt_q   <= 4'd0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_nseg_q <= hold_nseg_d;
      seg_cnt_q   <= seg_cnt_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (inp_acc) begin
      hold_data_q <= sdp.inp_data;
    end
  end
endmodule

// File: tb/tb_nvdla_sdp_core_split.sv
// tb/tb_nvdla_sdp_core_split.sv - bench for the SDP splitter at RATIO=4 and RATIO=1
// Queue-of-beats reference model per instance; directed phases plus random traffic.
module tb_nvdla_sdp_core_split;
  logic nvdla_core_clk  = 1'b0;
  logic nvdla_core_rstn = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  nvdla_sdp_core_split_if #(.IW(512), .OW(128)) ia ();
  nvdla_sdp_core_split_if #(.IW(128), .OW(128)) ib ();

  nvdla_sdp_core_split #(.IW(512), .OW(128)) u_a (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .sdp            (ia)
  );

  nvdla_sdp_core_split #(.IW(128), .OW(128)) u_b (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .sdp            (ib)
  );

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beats_a = 0, beats_b = 0, words_a = 0;
  int    first_a = 0, last_a = 0;
  bit    acc_a = 0, acc_b = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int norm(input logic [4:0] n, input int r);
    return (n == 5'd0 || int'(n) > r) ? r : int'(n);
  endfunction

  task automatic new_word_a(input logic [4:0] n);
    for (int k = 0; k < 16; k++) ia.inp_data[k*32 +: 32] = $urandom;
    ia.inp_nseg = n;
  endtask

  task automatic new_word_b();
    for (int k = 0; k < 4; k++) ib.inp_data[k*32 +: 32] = $urandom;
    ib.inp_nseg = 5'($urandom % 32);
  endtask

  // The model holds the remaining beats of the one word the splitter may hold.
  task automatic step_a();
    bit exp_rdy, oacc;
    int n;
    exp_rdy = (qa.size() == 0) || (ia.out_prdy && qa.size() == 1);
    chk("a_inp_prdy", 128'(ia.inp_prdy), 128'(exp_rdy));
    chk("a_out_pvld", 128'(ia.out_pvld), 128'(qa.size() != 0));
    if (qa.size() != 0) begin
      chk("a_out_data", ia.out_data, qa[0].data);
      chk("a_out_last", 128'(ia.out_last), 128'(qa[0].last));
    end else begin
      chk("a_out_last_idle", 128'(ia.out_last), 128'd0);
    end
    oacc  = (qa.size() != 0) && ia.out_prdy;
    acc_a = ia.inp_pvld && exp_rdy;
    if (oacc) begin
      void'(qa.pop_front());
      if (beats_a == 0) first_a = cyc;
      last_a = cyc;
      beats_a++;
    end
    if (acc_a) begin
      n = norm(ia.inp_nseg, 4);
      for (int k = 0; k < n; k++) qa.push_back('{data: ia.inp_data[k*128 +: 128], last: (k == n - 1)});
      words_a++;
    end
  endtask

  task automatic step_b();
    bit exp_rdy, oacc;
    exp_rdy = (qb.size() == 0) || (ib.out_prdy && qb.size() == 1);
    chk("b_inp_prdy", 128'(ib.inp_prdy), 128'(exp_rdy));
    chk("b_out_pvld", 128'(ib.out_pvld), 128'(qb.size() != 0));
    if (qb.size() != 0) begin
      chk("b_out_data", ib.out_data, qb[0].data);
      chk("b_out_last", 128'(ib.out_last), 128'(qb[0].last));
    end else begin
      chk("b_out_last_idle", 128'(ib.out_last), 128'd0);
    end
    oacc  = (qb.size() != 0) && ib.out_prdy;
    acc_b = ib.inp_pvld && exp_rdy;
    if (oacc) begin
      void'(qb.pop_front());
      beats_b++;
    end
    if (acc_b) qb.push_back('{data: ib.inp_data, last: 1'b1});
  endtask

  task automatic cycle();
    @(negedge nvdla_core_clk);
    step_a();
    step_b();
    cyc++;
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_a_pvld"}, 128'(ia.out_pvld), 128'd0);
    chk({tag, "_a_last"}, 128'(ia.out_last), 128'd0);
    chk({tag, "_a_prdy"}, 128'(ia.inp_prdy), 128'd1);
    chk({tag, "_b_pvld"}, 128'(ib.out_pvld), 128'd0);
    chk({tag, "_b_prdy"}, 128'(ib.inp_prdy), 128'd1);
  endtask

  initial begin
    logic [4:0] plist [6];
    int idx;
    plist = '{5'd2, 5'd0, 5'd9, 5'd1, 5'd3, 5'd4};

    ia.inp_pvld = 1'b1;
    ia.out_prdy = 1'b0;
    new_word_a(5'd4);
    ib.inp_pvld = 1'b1;
    ib.out_prdy = 1'b0;
    new_word_b();

    // Reset held with valid asserted upstream.
    repeat (3) begin
      @(posedge nvdla_core_clk);
      #1;
      chk_reset_state("rst");
    end

    // Single full word {D,C,B,A}.
    new_word_a(5'd4);
    ia.out_prdy = 1'b1;
    ib.inp_pvld = 1'b0;
    ib.out_prdy = 1'b1;
    nvdla_core_rstn = 1'b1;
    cycle();
    ia.inp_pvld = 1'b0;
    repeat (6) cycle();

    // Back-to-back streaming of three full words.
    beats_a = 0;
    words_a = 0;
    ia.inp_pvld = 1'b1;
    new_word_a(5'd4);
    for (int i = 0; i < 40 && words_a < 3; i++) begin
      cycle();
      if (acc_a) new_word_a(5'd4);
    end
    ia.inp_pvld = 1'b0;
    repeat (6) cycle();
    chk("stream_beats", 128'(beats_a), 128'd12);
    chk("stream_span", 128'(last_a - first_a + 1), 128'd12);

    // Partial and out-of-range segment counts.
    beats_a = 0;
    idx = 0;
    ia.inp_pvld = 1'b1;
    new_word_a(plist[0]);
    for (int i = 0; i < 60 && idx < 6; i++) begin
      cycle();
      if (acc_a) begin
        idx++;
        if (idx < 6) new_word_a(plist[idx]);
      end
    end
    ia.inp_pvld = 1'b0;
    repeat (6) cycle();
    chk("partial_beats", 128'(beats_a), 128'd18);

    // Random traffic with random backpressure on both instances.
    ia.inp_pvld = 1'b0;
    ib.inp_pvld = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ia.out_prdy = 1'($urandom % 2);
      ib.out_prdy = 1'($urandom % 2);
      if (!ia.inp_pvld || acc_a) begin
        ia.inp_pvld = ($urandom % 3) != 0;
        new_word_a(5'($urandom % 32));
      end
      if (!ib.inp_pvld || acc_b) begin
        ib.inp_pvld = ($urandom % 3) != 0;
        new_word_b();
      end
      cycle();
    end
    ia.inp_pvld = 1'b0;
    ib.inp_pvld = 1'b0;
    ia.out_prdy = 1'b1;
    ib.out_prdy = 1'b1;
    repeat (8) cycle();

    // Reset after two beats of a four-segment word, RATIO=1 streaming alongside.
    ib.inp_pvld = 1'b1;
    new_word_b();
    ia.inp_pvld = 1'b1;
    new_word_a(5'd4);
    cycle();
    if (acc_b) new_word_b();
    ia.inp_pvld = 1'b0;
    repeat (2) begin
      cycle();
      if (acc_b) new_word_b();
    end
    nvdla_core_rstn = 1'b0;
    #1;
    chk_reset_state("midrst");
    qa.delete();
    qb.delete();
    @(posedge nvdla_core_clk);
    #1;
    chk_reset_state("midrst_hold");
    nvdla_core_rstn = 1'b1;
    beats_a = 0;
    beats_b = 0;
    new_word_a(5'd4);
    ia.inp_pvld = 1'b1;
    new_word_b();
    for (int i = 0; i < 10; i++) begin
      cycle();
      ia.inp_pvld = 1'b0;
      if (acc_b) new_word_b();
    end
    chk("post_rst_a_beats", 128'(beats_a), 128'd4);
    chk("post_rst_b_beats", 128'(beats_b), 128'd9);
    ib.inp_pvld = 1'b0;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nvdla_sdp_core_split.md
# nvdla_sdp_core_split

Width-reducing splitter on the SDP output path: accepts one wide word per handshake and emits it as RATIO narrow beats, lowest segment first. It is the mirror of the SDP narrow-to-wide packer and sits downstream of the SDP core datapath, feeding the narrower write-DMA request interface. A per-word segment count allows truncated last words, for example at a surface edge, so unused segments are never emitted.

## Interface
Parameters:
- IW, 512: input (wide) data width.
- OW, 128: output (narrow) data width.
- RATIO, IW/OW: segments per word. Legal values are 1, 2, 4, 8, 16; any other value is unsupported.

Ports:
- nvdla_core_clk  input  1  clock.
- nvdla_core_rstn  input  1  reset; asynchronous, active-low. Clock is nvdla_core_clk.
- inp_pvld  input  1  wide word valid.
- inp_prdy  output  1  wide word ready.
- inp_data  input  IW  wide word; segment k is bits [k*OW +: OW].
- inp_nseg  input  5  number of valid segments in this word, 1..RATIO. A value of 0 or any value above RATIO means RATIO.
- out_pvld  output  1  narrow beat valid.
- out_prdy  input  1  narrow beat ready.
- out_data  output  OW  narrow beat.
- out_last  output  1  marks the final beat of the current word.

## Operation
- **Holding register:** one entry, made up of hold_data[IW], hold_nseg[5] (already normalised to 1..RATIO) and hold_vld.
- **Segment counter:** seg_cnt, 4 bits, selects the segment currently presented.
- **Input acceptance:** inp_acc = inp_pvld & inp_prdy.
- **Output acceptance:** out_acc = out_pvld & out_prdy.
- **Last-beat condition:** is_last = (seg_cnt == hold_nseg-1).
- **Ready rule:** inp_prdy = !hold_vld | (out_acc & is_last).
  - inp_prdy is purely combinational from out_prdy and registered state.
  - There is no other combinational path from input to output.
- **Output signals:**
  - out_pvld = hold_vld.
  - out_data = hold_data[seg_cnt*OW +: OW].
  - out_last = hold_vld & is_last.
- **On inp_acc:**
  - Load hold_data with inp_data.
  - Load hold_nseg with the normalised inp_nseg.
  - Set hold_vld = 1 and seg_cnt = 0.
- **On out_acc & !is_last:** seg_cnt increments by 1.
- **On out_acc & is_last & !inp_pvld:** hold_vld clears and seg_cnt returns to 0.
- **Simultaneous last-beat accept and new input:** the new word loads in the same cycle, with no bubble.
- **While out_pvld=1 & out_prdy=0:** out_data, out_last and seg_cnt hold stable, which is the standard valid/ready rule.
- **RATIO=1:** every beat is last; the block degenerates to a single pipeline register with pass-through of the ready/valid handshake.
- **Normalisation:** inp_nseg is compared as unsigned 5-bit, so RATIO=16 accepts the value 16. For RATIO<16, values above RATIO are clamped to RATIO.
- **Data registers:** hold_data is not reset. out_data is don't-care while out_pvld=0.

## Timing
- **Reset values:**
  - out_pvld=0, out_last=0.
  - inp_prdy=1, since hold_vld=0.
  - seg_cnt=0, hold_nseg=RATIO.
- **Latency:** a word accepted at clock edge N presents segment 0 on out_pvld in the cycle following edge N.
- **Throughput:** with out_prdy held high, a word of n segments occupies exactly n output cycles. Back-to-back words sustain one beat per cycle with no gaps.
- **Reset mid-word:** asynchronous assertion immediately drops out_pvld and discards the remaining segments. After deassertion, the next word starts at segment 0.
- **Upstream stall:** if the upstream deasserts inp_pvld mid-word, there is no effect, because the word is already held.
- **Downstream stall on the last beat:** inp_prdy stays 0 until out_prdy returns.

## Test plan
- **Reset:** assert reset with inp_pvld=1 -> out_pvld=0 and inp_prdy=1 throughout reset; no beat is emitted before the first post-reset edge.
- **Single full word:** IW=512, OW=128, inp_data = {D,C,B,A}, inp_nseg=4, out_prdy=1 -> out_data = A, B, C, D on 4 consecutive cycles; out_last only with D; inp_prdy=0 for the first 3 beats and 1 during beat D.
- **Back-to-back streaming:** 3 full words, out_prdy=1, inp_pvld=1 continuously -> 12 consecutive beats with no idle cycle; out_last on beats 4, 8 and 12.
- **Partial word:** inp_nseg=2 -> only A and B emitted, out_last on B, next word accepted during B. inp_nseg=0 and inp_nseg=9 each emit all 4 segments.
- **Backpressure:** out_prdy toggling randomly, including low on the last beat -> out_data/out_last stable while stalled; inp_prdy=0 until the last beat is accepted; no beat lost or duplicated; the sequence matches the scoreboard.
- **Reset mid-word:** reset asserted after 2 beats of a 4-segment word -> out_pvld drops immediately; after release, the next word starts at segment 0 with a correct sequence. Repeat with RATIO=1, where every beat carries out_last=1 at full rate.
